// File: rtl/uart_program_loader_pkg.sv
// Shared defaults and FSM state encodings for the UART program loader.
package uart_program_loader_pkg;

  localparam int CLKS_PER_BIT_DEF     = 1042;
  localparam int DATA_WIDTH_DEF       = 8;
  localparam int MEM_ADDR_WIDTH_DEF   = 4;
  localparam int MEM_REGISTERS_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  // Sampling point inside the start bit, measured from the first low cycle.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_program_loader_uart_rx_core.sv
// 8N1 receiver bit timing: start-bit qualification, data shift-in, stop-bit check.
// byte_valid_o / frame_err_o are combinational pulses in the stop-bit sample cycle.
module uart_rx_core
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] byte_o,
  output logic                  byte_valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LP_HALF_M1 = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [CNT_W-1:0] LP_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LP_LAST    = BIT_W'(DATA_WIDTH - 1);

  state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_baud, w_baud_nxt;
  logic [BIT_W-1:0]      r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;

  // Control registers; a soft clear or reset returns the receiver to IDLE.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Data shift register; only ever read when byte_valid_o is high.
  always_ff @(posedge clk_i) begin
    r_shift <= w_shift_nxt;
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en_i && !rx_i) begin
          w_state_nxt = ST_START;
          w_baud_nxt  = '0;
        end
      end
      ST_START: begin
        if (r_baud == LP_HALF_M1) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = rx_i ? ST_IDLE : ST_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_baud == LP_FULL_M1) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {rx_i, r_shift[DATA_WIDTH-1:1]};
          if (r_bit == LP_LAST) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_baud == LP_FULL_M1) begin
          w_baud_nxt   = '0;
          byte_valid_o = rx_i;
          frame_err_o  = !rx_i;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign byte_o = r_shift;
  assign busy_o = (r_state != ST_IDLE);

endmodule

// File: rtl/uart_program_loader.sv
// Loads UART bytes into program memory at ascending addresses while programming mode is on.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT         = CLKS_PER_BIT_DEF,
  parameter int DATA_WIDTH           = DATA_WIDTH_DEF,
  parameter int MEMORY_ADDRESS_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int MEMORY_REGISTERS     = MEM_REGISTERS_DEF
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            p_programm_i,
  input  logic                            rx_i,
  output logic                            mem_we_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_data_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            frame_err_o
);

  localparam int AW = MEMORY_ADDRESS_WIDTH;
  localparam logic [AW:0] LP_FULL = (AW+1)'(MEMORY_REGISTERS);

  logic                  w_clear;
  logic                  w_full;
  logic                  w_rx_en;
  logic [DATA_WIDTH-1:0] w_byte;
  logic                  w_byte_valid;
  logic                  w_frame_err;
  logic                  w_core_busy;

  // Extra top bit keeps the counter from wrapping onto address 0 at completion.
  logic [AW:0]           r_addr;
  logic                  r_we;
  logic [AW-1:0]         r_addr_out;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_ferr;

  assign w_clear = reset_i | ~p_programm_i;
  assign w_full  = (r_addr == LP_FULL);
  assign w_rx_en = ~r_done & ~w_full;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_rx (
    .clk_i        (clk_i),
    .clear_i      (w_clear),
    .en_i         (w_rx_en),
    .rx_i         (rx_i),
    .byte_o       (w_byte),
    .byte_valid_o (w_byte_valid),
    .frame_err_o  (w_frame_err),
    .busy_o       (w_core_busy)
  );

  // Write strobe, address/data hold registers, completion and frame-error flags.
  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_addr_out <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_we   <= w_byte_valid & ~w_full;
      r_done <= r_done | w_full;
      if (w_byte_valid && !w_full) begin
        r_addr_out <= r_addr[AW-1:0];
        r_data     <= w_byte;
        r_addr     <= r_addr + 1'b1;
      end
      if (w_frame_err) begin
        r_ferr <= 1'b1;
      end
    end
  end

  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr_out;
  assign mem_data_o  = r_data;
  assign busy_o      = w_core_busy | r_we;
  assign done_o      = r_done;
  assign frame_err_o = r_ferr;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with CLKS_PER_BIT=4.
module tb_uart_program_loader;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       p_programm_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       mem_we_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_o;
  logic       busy_o;
  logic       done_o;
  logic       frame_err_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] q_addr[$];
  logic [7:0] q_data[$];

  uart_program_loader #(
    .CLKS_PER_BIT         (CPB),
    .DATA_WIDTH           (8),
    .MEMORY_ADDRESS_WIDTH (4),
    .MEMORY_REGISTERS     (16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .p_programm_i (p_programm_i),
    .rx_i         (rx_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  // Write-port monitor: log every write, and no write may happen outside programming mode.
  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      n_cmp++;
      assert (p_programm_i === 1'b1) else begin
        n_err++;
        $error("FAIL we_while_prog_low: observed p_programm=%0b required 1", p_programm_i);
      end
      q_addr.push_back(mem_addr_o);
      q_data.push_back(mem_data_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (CPB) tick();
    end
    rx_i = stop_bit;
    repeat (CPB) tick();
    rx_i = 1'b1;
  endtask

  task automatic do_reset();
    rx_i = 1'b1;
    p_programm_i = 1'b1;
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
    q_addr.delete();
    q_data.delete();
    repeat (2) tick();
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
    if (idx < q_addr.size()) begin
      chk({tag, "_addr"}, 32'(q_addr[idx]), 32'(a));
      chk({tag, "_data"}, 32'(q_data[idx]), 32'(d));
    end else begin
      chk({tag, "_missing"}, 32'(q_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_we"},   32'(mem_we_o),    32'h0);
    chk({tag, "_addr"}, 32'(mem_addr_o),  32'h0);
    chk({tag, "_data"}, 32'(mem_data_o),  32'h0);
    chk({tag, "_busy"}, 32'(busy_o),      32'h0);
    chk({tag, "_done"}, 32'(done_o),      32'h0);
    chk({tag, "_ferr"}, 32'(frame_err_o), 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk_idle_outputs("reset");
    reset_i = 1'b0;
    tick();

    // Two bytes
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (4) tick();
    chk("t1_count", 32'(q_addr.size()), 32'd2);
    chk_write("t1_w0", 0, 4'd0, 8'hA5);
    chk_write("t1_w1", 1, 4'd1, 8'h3C);
    chk("t1_ferr", 32'(frame_err_o), 32'h0);
    chk("t1_done", 32'(done_o), 32'h0);
    chk("t1_hold_addr", 32'(mem_addr_o), 32'h1);
    chk("t1_hold_data", 32'(mem_data_o), 32'h3C);

    // Sixteen back-to-back bytes, then one ignored
    do_reset();
    for (int k = 0; k < 16; k++) begin
      send_byte(8'(k), 1'b1);
      if (k == 14) chk("t2_done_early", 32'(done_o), 32'h0);
    end
    chk("t2_done", 32'(done_o), 32'h1);
    chk("t2_count", 32'(q_addr.size()), 32'd16);
    for (int k = 0; k < 16; k++) chk_write("t2_w", k, 4'(k), 8'(k));
    send_byte(8'hFF, 1'b1);
    repeat (4) tick();
    chk("t2_count_after", 32'(q_addr.size()), 32'd16);
    chk("t2_busy_after", 32'(busy_o), 32'h0);
    chk("t2_hold_addr", 32'(mem_addr_o), 32'hF);
    chk("t2_hold_data", 32'(mem_data_o), 32'h0F);

    // Frame error, then a good byte at the same address
    do_reset();
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) tick();
    chk("t3_ferr_set", 32'(frame_err_o), 32'h1);
    chk("t3_no_write", 32'(q_addr.size()), 32'd0);
    send_byte(8'h66, 1'b1);
    repeat (4) tick();
    chk("t3_count", 32'(q_addr.size()), 32'd1);
    chk_write("t3_w0", 0, 4'd0, 8'h66);
    chk("t3_ferr_sticky", 32'(frame_err_o), 32'h1);

    // One-cycle glitch on rx
    do_reset();
    rx_i = 1'b0;
    tick();
    rx_i = 1'b1;
    chk("t4_busy_start", 32'(busy_o), 32'h1);
    repeat (3) tick();
    chk("t4_busy_back", 32'(busy_o), 32'h0);
    repeat (40) tick();
    chk("t4_no_write", 32'(q_addr.size()), 32'd0);
    chk("t4_ferr", 32'(frame_err_o), 32'h0);

    // Programming mode dropped mid-frame
    do_reset();
    rx_i = 1'b0;
    repeat (CPB) tick();
    rx_i = 1'b1; repeat (CPB) tick();
    rx_i = 1'b0; repeat (CPB) tick();
    rx_i = 1'b1; repeat (CPB) tick();
    chk("t5_busy_mid", 32'(busy_o), 32'h1);
    p_programm_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_busy_low", 32'(busy_o), 32'h0);
    end
    repeat (40) tick();
    p_programm_i = 1'b1;
    repeat (2 * CPB) tick();
    send_byte(8'h81, 1'b1);
    repeat (4) tick();
    chk("t5_count", 32'(q_addr.size()), 32'd1);
    chk_write("t5_w0", 0, 4'd0, 8'h81);

    // Reset pulse after five writes
    do_reset();
    for (int k = 0; k < 5; k++) send_byte(8'h11 + 8'(k), 1'b1);
    repeat (2) tick();
    chk("t6_count", 32'(q_addr.size()), 32'd5);
    chk("t6_pre_addr", 32'(mem_addr_o), 32'h4);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk_idle_outputs("t6_after_reset");
    q_addr.delete();
    q_data.delete();
    tick();
    send_byte(8'h42, 1'b1);
    repeat (4) tick();
    chk("t6_count_new", 32'(q_addr.size()), 32'd1);
    chk_write("t6_w0", 0, 4'd0, 8'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
